// File: rtl/dut_sf_fifo.sv
// Store-and-forward frame FIFO: buffers complete rx frames, replays them with an inter-frame gap.
// Optional saturating frame statistics are enabled with the DUT_STATS_EN macro.
module dut_sf_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IFG   = 2,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rxd,
  input  logic          rx_dv,
  output logic [DW-1:0] txd,
  output logic          tx_en,
  output logic          drop_pulse
`ifdef DUT_STATS_EN
  ,
  output logic [CW-1:0] rx_frames,
  output logic [CW-1:0] tx_frames,
  output logic [CW-1:0] drop_frames
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DW + 1;

  if (DW < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || IFG > 15 || CW < 1) begin : g_param_check
    $error("dut_sf_fifo: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_c;
  logic [PW-1:0] wr_ptr_s;
  logic [PW-1:0] frames_avail;
  logic [DW-1:0] hold_data;
  logic          hold_vld;
  logic          drop;
  logic          skip;
  state_t        state;
  logic [3:0]    gap_cnt;

  logic [PW-1:0] fill_c;
  logic          full_c;
  logic          frame_end_c;
  logic          blocked_c;
  logic          wr_en_c;
  logic          commit_c;
  logic          abort_c;
  logic [EW-1:0] rd_word_c;
  logic          rd_last_c;

  // Write-side decisions for the word sitting in the hold register.
  always_comb begin
    fill_c      = wr_ptr_s - rd_ptr;
    full_c      = (fill_c == PW'(DEPTH));
    frame_end_c = hold_vld & ~rx_dv;
    blocked_c   = hold_vld & (drop | full_c);
    wr_en_c     = hold_vld & ~blocked_c;
    commit_c    = frame_end_c & ~blocked_c;
    abort_c     = frame_end_c & blocked_c;
    rd_word_c   = mem[rd_ptr[AW-1:0]];
    rd_last_c   = (state == S_SEND) & rd_word_c[DW];
  end

  // Entry format {last, data}; last is known once rx_dv is seen low behind the held word.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_s[AW-1:0]] <= {~rx_dv, hold_data};
    end
  end

  // Receive side: hold register, speculative writes, commit or rollback at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data  <= '0;
      hold_vld   <= 1'b0;
      drop       <= 1'b0;
      skip       <= 1'b1;
      wr_ptr_s   <= '0;
      wr_ptr_c   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      // A frame already running when reset releases is ignored until rx_dv drops.
      if (skip) begin
        skip <= rx_dv;
      end
      hold_vld <= rx_dv & ~skip;
      if (rx_dv) begin
        hold_data <= rxd;
      end
      if (wr_en_c) begin
        wr_ptr_s <= wr_ptr_s + PW'(1);
      end
      if (blocked_c && rx_dv) begin
        drop <= 1'b1;
      end
      if (commit_c) begin
        wr_ptr_c <= wr_ptr_s + PW'(1);
      end
      if (abort_c) begin
        wr_ptr_s   <= wr_ptr_c;
        drop       <= 1'b0;
        drop_pulse <= 1'b1;
      end
    end
  end

  // Transmit FSM: replays one committed frame contiguously, then idles for the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rd_ptr       <= '0;
      frames_avail <= '0;
      gap_cnt      <= '0;
      txd          <= '0;
      tx_en        <= 1'b0;
    end else begin
      case ({commit_c, rd_last_c})
        2'b10:   frames_avail <= frames_avail + PW'(1);
        2'b01:   frames_avail <= frames_avail - PW'(1);
        default: ;
      endcase
      case (state)
        S_IDLE: begin
          tx_en <= 1'b0;
          if (frames_avail != '0) begin
            state <= S_SEND;
          end
        end
        S_SEND: begin
          txd    <= rd_word_c[DW-1:0];
          tx_en  <= 1'b1;
          rd_ptr <= rd_ptr + PW'(1);
          if (rd_word_c[DW]) begin
            if (IFG > 0) begin
              state   <= S_GAP;
              gap_cnt <= 4'(IFG - 1);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          tx_en <= 1'b0;
          if (gap_cnt == 4'd0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef DUT_STATS_EN
  // Saturating frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_frames   <= '0;
      tx_frames   <= '0;
      drop_frames <= '0;
    end else begin
      if (commit_c && rx_frames != '1) begin
        rx_frames <= rx_frames + CW'(1);
      end
      if (rd_last_c && tx_frames != '1) begin
        tx_frames <= tx_frames + CW'(1);
      end
      if (abort_c && drop_frames != '1) begin
        drop_frames <= drop_frames + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dut_sf_fifo.sv
// Directed bench for dut_sf_fifo: scoreboard of expected tx words, immediate-assertion checks.
module tb_dut_sf_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned IFG   = 2;
  localparam int unsigned CW    = 16;

  typedef logic [DW-1:0] bq_t[$];
  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } item_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rxd;
  logic          rx_dv;
  logic [DW-1:0] txd;
  logic          tx_en;
  logic          drop_pulse;
`ifdef DUT_STATS_EN
  logic [CW-1:0] rx_frames;
  logic [CW-1:0] tx_frames;
  logic [CW-1:0] drop_frames;
`endif

  dut_sf_fifo #(.DW(DW), .DEPTH(DEPTH), .IFG(IFG), .CW(CW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_dv      (rx_dv),
    .txd        (txd),
    .tx_en      (tx_en),
    .drop_pulse (drop_pulse)
`ifdef DUT_STATS_EN
    ,
    .rx_frames  (rx_frames),
    .tx_frames  (tx_frames),
    .drop_frames(drop_frames)
`endif
  );

  always #5 clk = ~clk;

  item_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    low_run  = 0;
  int    last_gap = 0;
  int    start_cyc = 0;
  int    fall_cyc = 0;
  int    drop_cnt = 0;
  int    exp_drop = 0;
  int    exp_rx   = 0;
  int    exp_tx   = 0;
  bit    mid_frame = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_stats(input string tag);
`ifdef DUT_STATS_EN
    chk({tag, "_rx_frames"}, 32'(rx_frames), 32'(exp_rx));
    chk({tag, "_tx_frames"}, 32'(tx_frames), 32'(exp_tx));
    chk({tag, "_drop_frames"}, 32'(drop_frames), 32'(exp_drop));
`endif
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: sampled 1ns after each rising edge, pops the scoreboard per tx word.
  always @(posedge clk) begin
    item_t it;
    #1;
    if (rst) begin
      mid_frame = 1'b0;
      low_run   = 0;
    end else begin
      if (drop_pulse) drop_cnt++;
      if (tx_en) begin
        if (!mid_frame) begin
          last_gap  = low_run;
          start_cyc = cyc;
          chk("ifg_min", 32'(low_run >= int'(IFG + 1)), 32'd1);
        end
        low_run = 0;
        n_checks++;
        assert (sb.size() != 0) n_pass++;
        else $error("FAIL unexpected_tx: observed txd=%0h with tx_en, expected idle", txd);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          chk("tx_data", 32'(txd), 32'(it.data));
          mid_frame = !it.last;
        end
      end else begin
        if (mid_frame) begin
          chk("tx_contig", 32'(tx_en), 32'd1);
          mid_frame = 1'b0;
        end
        low_run++;
      end
    end
  end

  task automatic push_frame(input bq_t w);
    item_t it;
    for (int i = 0; i < w.size(); i++) begin
      it.data = w[i];
      it.last = (i == w.size() - 1);
      sb.push_back(it);
    end
  endtask

  // Drive one frame on consecutive cycles; returns on the cycle rx_dv is driven low.
  task automatic send(input bq_t w, input bit push);
    if (push) push_frame(w);
    for (int i = 0; i < w.size(); i++) begin
      @(negedge clk);
      rx_dv = 1'b1;
      rxd   = w[i];
    end
    @(negedge clk);
    rx_dv    = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || tx_en) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (IFG + 4) @(negedge clk);
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t f, g;
    logic d;
    rst   = 1'b1;
    rx_dv = 1'b0;
    rxd   = '0;
    repeat (5) @(negedge clk);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_txd", 32'(txd), 32'd0);
    chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    chk_stats("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Four-word frame: latency, order and hold of txd afterwards.
    f = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(f, 1'b1);
    @(negedge clk);
    chk("f4_drop_pulse", 32'(drop_pulse), 32'd0);
    wait_drain("f4");
    chk("f4_latency", 32'(start_cyc - fall_cyc), 32'd3);
    chk("f4_txd_hold", 32'(txd), 32'h44);
    exp_rx++; exp_tx++;
    chk_stats("f4");

    // Single-word frame.
    f = '{8'hA5};
    send(f, 1'b1);
    @(negedge clk);
    chk("f1_drop_pulse", 32'(drop_pulse), 32'd0);
    wait_drain("f1");
    chk("f1_txd_hold", 32'(txd), 32'hA5);
    exp_rx++; exp_tx++;
    chk_stats("f1");

    // Two three-word frames with a one-cycle rx gap: exact inter-frame gap.
    f = '{8'h31, 8'h32, 8'h33};
    g = '{8'h41, 8'h42, 8'h43};
    send(f, 1'b1);
    send(g, 1'b1);
    wait_drain("b2b");
    chk("b2b_gap", 32'(last_gap), 32'(IFG + 1));
    exp_rx += 2; exp_tx += 2;
    chk_stats("b2b");

    // Oversized frame is dropped, following frame passes.
    f = {};
    for (int i = 0; i < DEPTH + 1; i++) f.push_back(DW'(8'h80 + i));
    send(f, 1'b0);
    @(negedge clk);
    chk("ovf_drop_pulse", 32'(drop_pulse), 32'd1);
    @(negedge clk);
    chk("ovf_drop_single", 32'(drop_pulse), 32'd0);
    exp_drop++;
    f = '{8'h01, 8'h02};
    send(f, 1'b1);
    @(negedge clk);
    chk("post_ovf_drop_pulse", 32'(drop_pulse), 32'd0);
    wait_drain("ovf");
    exp_rx++; exp_tx++;
    chk_stats("ovf");

    // Busy transmitter: second frame is either whole or dropped, never partial.
    f = {};
    for (int i = 0; i < 12; i++) f.push_back(DW'(8'hC0 + i));
    send(f, 1'b1);
    @(negedge clk);
    g = {};
    for (int i = 0; i < 8; i++) g.push_back(DW'(8'hD0 + i));
    send(g, 1'b0);
    @(negedge clk);
    d = drop_pulse;
    if (d) exp_drop++;
    else begin
      push_frame(g);
      exp_rx++; exp_tx++;
    end
    exp_rx++; exp_tx++;
    f = '{8'hE1, 8'hE2};
    send(f, 1'b1);
    exp_rx++; exp_tx++;
    wait_drain("busy");
    chk_stats("busy");

    // Reset mid-tx and mid-rx.
    f = {};
    for (int i = 0; i < 8; i++) f.push_back(DW'(8'h50 + i));
    send(f, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_dv = 1'b1;
      rxd   = DW'(8'h60 + i);
    end
    @(negedge clk);
    rst   = 1'b1;
    rxd   = 8'h63;
    sb.delete();
    exp_rx = 0; exp_tx = 0; exp_drop = 0;
    @(negedge clk);
    rst   = 1'b0;
    rxd   = 8'h64;
    chk("mid_rst_tx_en", 32'(tx_en), 32'd0);
    chk("mid_rst_txd", 32'(txd), 32'd0);
    chk("mid_rst_drop_pulse", 32'(drop_pulse), 32'd0);
    drop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rxd = DW'(8'h65 + i);
    end
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_tx", 32'(tx_en), 32'd0);
    chk_stats("mid_rst");
    f = '{8'h71, 8'h72, 8'h73};
    send(f, 1'b1);
    @(negedge clk);
    chk("after_rst_drop_pulse", 32'(drop_pulse), 32'd0);
    wait_drain("after_rst");
    exp_rx++; exp_tx++;
    chk_stats("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
